// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one iteration per cycle, 32-cycle start-to-strobe latency.
module multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    // state | meaning
    // IDLE  | waiting for a start edge; result/exception hold
    // MUL   | shift-add iterations, multiplier bit cnt per cycle
    // DIV   | restoring divide iterations, one quotient bit per cycle, MSB first
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sign;
    logic [63:0] acc;
    logic [31:0] rem;
    logic [31:0] quo;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] acc_next;
    logic [63:0] prod;
    logic        mul_ovf;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        q_bit;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_signed;
    logic        div_zero;
    logic        div_ovf;

    // Two's-complement negation of 0x80000000 yields 0x80000000, which read unsigned is 2^31.
    assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    assign acc_next = mag_b[cnt] ? acc + ({32'd0, mag_a} << cnt) : acc;
    assign prod     = sign ? -acc_next : acc_next;
    assign mul_ovf  = prod[63:32] != {32{prod[31]}};

    // The dividend magnitude is shifted out of quo MSB-first while quotient bits shift in.
    assign rem_shift  = {rem, quo[31]};
    assign diff       = rem_shift - {1'b0, mag_b};
    assign q_bit      = ~diff[32];
    assign rem_next   = q_bit ? diff : rem_shift;
    assign quo_next   = {quo[30:0], q_bit};
    assign quo_signed = sign ? -quo_next : quo_next;
    assign div_zero   = mag_b == 32'd0;
    assign div_ovf    = ~sign & quo_next[31];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            mag_a          <= 32'd0;
            mag_b          <= 32'd0;
            sign           <= 1'b0;
            acc            <= 64'd0;
            rem            <= 32'd0;
            quo            <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        data_result    <= prod[31:0];
                        data_exception <= mul_ovf;
                        data_resultRDY <= 1'b1;
                        state          <= IDLE;
                    end
                end
                DIV: begin
                    rem <= rem_next[31:0];
                    quo <= quo_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        data_result    <= div_zero ? 32'd0 : quo_signed;
                        data_exception <= div_zero | div_ovf;
                        data_resultRDY <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: ;
            endcase
            // A start edge wins over any iteration in flight but not over a same-edge completion strobe.
            if (ctrl_MULT || ctrl_DIV) begin
                mag_a <= abs_a;
                mag_b <= abs_b;
                sign  <= data_operandA[31] ^ data_operandB[31];
                cnt   <= 5'd0;
                acc   <= 64'd0;
                rem   <= 32'd0;
                quo   <= abs_a;
                state <= ctrl_MULT ? MUL : DIV;
            end
        end
    end
endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: expected results are pushed to a scoreboard at
// each start and compared when the ready strobe appears.
module tb_multdiv;
    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int          checks;
    int          errors;
    logic [32:0] sb[$];
    logic [32:0] last_exp;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    // {exception, result} from signed 64-bit arithmetic.
    function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p[63:32] != {32{p[31]}}), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, input bit push);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (push) sb.push_back(model(m, a, b));
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_strobe(input string name, input bit chain, input bit cm,
                               input logic [31:0] ca, input logic [31:0] cb);
        logic [32:0] exp;
        for (int k = 1; k <= 32; k++) begin
            if (chain && k == 32) begin
                data_operandA = ca;
                data_operandB = cb;
                ctrl_MULT     = cm;
                ctrl_DIV      = ~cm;
                sb.push_back(model(cm, ca, cb));
            end
            @(posedge clock);
            #1;
            if (chain && k == 32) begin
                ctrl_MULT     = 1'b0;
                ctrl_DIV      = 1'b0;
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
            checks++;
            if (k < 32) begin
                if (data_resultRDY !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_strobe at edge %0d: got rdy=%b need 0", name, k, data_resultRDY);
                end
            end else begin
                exp = (sb.size() > 0) ? sb.pop_front() : 33'h0;
                last_exp = exp;
                if (data_resultRDY !== 1'b1) begin
                    errors++;
                    $display("FAIL %s strobe at E32: got rdy=%b need 1", name, data_resultRDY);
                end
                checks++;
                if (data_result !== exp[31:0]) begin
                    errors++;
                    $display("FAIL %s result: got %h need %h", name, data_result, exp[31:0]);
                end
                checks++;
                if (data_exception !== exp[32]) begin
                    errors++;
                    $display("FAIL %s exception: got %b need %b", name, data_exception, exp[32]);
                end
            end
        end
    endtask

    task automatic check_quiet(input string name, input int n, input bit hold);
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            checks++;
            if (data_resultRDY !== 1'b0) begin
                errors++;
                $display("FAIL %s quiet edge %0d: got rdy=%b need 0", name, k, data_resultRDY);
            end
            if (hold) begin
                checks++;
                if ({data_exception, data_result} !== last_exp) begin
                    errors++;
                    $display("FAIL %s hold edge %0d: got %b/%h need %b/%h", name, k,
                             data_exception, data_result, last_exp[32], last_exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({data_resultRDY, data_exception, data_result} !== 34'd0) begin
            errors++;
            $display("FAIL reset outputs: got rdy=%b exc=%b res=%h need all 0",
                     data_resultRDY, data_exception, data_result);
        end
        @(negedge clock);
        reset = 1'b0;
        last_exp = 33'd0;
        check_quiet("reset_idle", 3, 1'b1);
    endtask

    task automatic test_mul();
        logic [31:0] va[6] = '{32'h0000_0007, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_2345, 32'h7FFF_FFFF};
        logic [31:0] vb[6] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_6789, 32'h0000_0002};
        for (int i = 0; i < 6; i++) begin
            start_op(1'b1, 1'b0, va[i], vb[i], 1'b1);
            wait_strobe("mul", 1'b0, 1'b0, 32'd0, 32'd0);
            check_quiet("mul_after", 2, 1'b1);
        end
    endtask

    task automatic test_div();
        logic [31:0] va[8] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FFF9, 32'h8000_0000,
                               32'h0000_0005, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] vb[8] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0002,
                               32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0003};
        for (int i = 0; i < 8; i++) begin
            start_op(1'b0, 1'b1, va[i], vb[i], 1'b1);
            wait_strobe("div", 1'b0, 1'b0, 32'd0, 32'd0);
            check_quiet("div_after", 2, 1'b1);
        end
    endtask

    task automatic test_restart();
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        check_quiet("restart_pre", 9, 1'b1);
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1);
        wait_strobe("restart_div", 1'b0, 1'b0, 32'd0, 32'd0);
        check_quiet("restart_after", 5, 1'b1);
    endtask

    task automatic test_simultaneous();
        start_op(1'b1, 1'b1, 32'd6, 32'd3, 1'b1);
        wait_strobe("simul", 1'b0, 1'b0, 32'd0, 32'd0);
        check_quiet("simul_after", 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_op(1'b1, 1'b0, 32'd123, 32'hFFFF_FFD3, 1'b1);
        wait_strobe("b2b_first", 1'b1, 1'b0, 32'hFFFF_FC18, 32'd7);
        wait_strobe("b2b_second", 1'b0, 1'b0, 32'd0, 32'd0);
        check_quiet("b2b_after", 3, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        start_op(1'b1, 1'b0, 32'd5, 32'd5, 1'b0);
        check_quiet("rst_pre", 14, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({data_resultRDY, data_exception, data_result} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset outputs: got rdy=%b exc=%b res=%h need all 0",
                     data_resultRDY, data_exception, data_result);
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        last_exp = 33'd0;
        check_quiet("rst_no_strobe", 40, 1'b1);
        start_op(1'b0, 1'b1, 32'd9, 32'd3, 1'b1);
        wait_strobe("rst_then_div", 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        last_exp      = 33'd0;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        test_reset();
        test_mul();
        test_div();
        test_restart();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
